// File: rtl/huffman_decoder_pkg.sv
// Canonical Huffman code tables and shared types for the Huffman link decoder.
// The tables match the default code used by huffman_encoder.
package huffman_decoder_pkg;

    localparam int MAX_LEN   = 5;
    localparam int NUM_SYMS  = 7;
    localparam int LEN_W     = 3;
    localparam int TBL_SYM_W = 8;

    typedef logic [MAX_LEN-1:0]   code_t;
    typedef logic [LEN_W-1:0]     len_t;
    typedef logic [TBL_SYM_W-1:0] sym_t;
    typedef logic [2:0]           sym_idx_t;

    typedef struct packed {
        logic match;
        sym_t sym;
    } lookup_t;

    // Code 5=00 68=01 50=100 100=101 150=110 200=1110 250=11110; 11111 unassigned
    function automatic code_t canon_first(input len_t len);
        case (len)
            3'd2:    return 5'd0;
            3'd3:    return 5'd4;
            3'd4:    return 5'd14;
            3'd5:    return 5'd30;
            default: return 5'd0;
        endcase
    endfunction

    function automatic code_t canon_count(input len_t len);
        case (len)
            3'd2:    return 5'd2;
            3'd3:    return 5'd3;
            3'd4:    return 5'd1;
            3'd5:    return 5'd1;
            default: return 5'd0;
        endcase
    endfunction

    function automatic sym_idx_t canon_offs(input len_t len);
        case (len)
            3'd3:    return 3'd2;
            3'd4:    return 3'd5;
            3'd5:    return 3'd6;
            default: return 3'd0;
        endcase
    endfunction

    function automatic sym_t canon_sym(input sym_idx_t idx);
        case (idx)
            3'd0:    return 8'd5;
            3'd1:    return 8'd68;
            3'd2:    return 8'd50;
            3'd3:    return 8'd100;
            3'd4:    return 8'd150;
            3'd5:    return 8'd200;
            3'd6:    return 8'd250;
            default: return 8'd0;
        endcase
    endfunction

endpackage

// File: rtl/huffman_decoder_if.sv
// Stream-side signals of the Huffman decoder: encoded word input, symbol output,
// control (enable/flush) and the sticky error flag.
interface huffman_decoder_if #(
    parameter int IN_W  = 16,
    parameter int SYM_W = 8
);
    logic             enable;
    logic             in_valid;
    logic [IN_W-1:0]  data_in;
    logic             in_ready;
    logic             flush;
    logic             out_valid;
    logic [SYM_W-1:0] data_out;
    logic             out_ready;
    logic             err;

    modport master (
        output enable, in_valid, data_in, flush, out_ready,
        input  in_ready, out_valid, data_out, err
    );

    modport slave (
        input  enable, in_valid, data_in, flush, out_ready,
        output in_ready, out_valid, data_out, err
    );
endinterface

// File: rtl/huffman_canon_lookup.sv
// Combinational canonical-code match: a (code,len) pair hits when
// code-FIRST[len] < COUNT[len]; the symbol then comes from SYMTAB.
module huffman_canon_lookup
    import huffman_decoder_pkg::*;
(
    input  code_t   code,
    input  len_t    len,
    output lookup_t res
);
    code_t    diff;
    sym_idx_t idx;

    always_comb begin
        diff      = code - canon_first(len);
        // On a hit diff < COUNT <= 3, so its low bits are the full offset
        idx       = canon_offs(len) + diff[2:0];
        res.match = (diff < canon_count(len));
        res.sym   = res.match ? canon_sym(idx) : '0;
    end
endmodule

// File: rtl/huffman_decoder.sv
// Bit-serial canonical Huffman decoder: unpacks 16-bit words MSB first, one bit
// per clock, and emits one symbol per matched code; codes may span word boundaries.
module huffman_decoder
    import huffman_decoder_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int SYM_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    huffman_decoder_if.slave   bus
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EMIT   = 3'd3;
    localparam logic [2:0] S_ERR    = 3'd4;
    localparam int BCNT_W = $clog2(IN_W + 1);

    logic [2:0]        state;
    logic [IN_W-1:0]   shreg;
    logic [BCNT_W-1:0] bcnt;
    code_t             code;
    len_t              len;
    logic [SYM_W-1:0]  sym_q;
    logic              flush_pend;
    code_t             code_nxt;
    len_t              len_nxt;
    lookup_t           lk;

    assign code_nxt = {code[MAX_LEN-2:0], shreg[IN_W-1]};
    assign len_nxt  = len + len_t'(1);

    huffman_canon_lookup u_lookup (
        .code (code_nxt),
        .len  (len_nxt),
        .res  (lk)
    );

    // A flush in the same cycle as a word offer refuses the word
    assign bus.in_ready  = (state == S_FETCH) && bus.enable && !bus.flush;
    assign bus.out_valid = (state == S_EMIT);
    assign bus.data_out  = sym_q;
    assign bus.err       = (state == S_ERR);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            shreg      <= '0;
            bcnt       <= '0;
            code       <= '0;
            len        <= '0;
            sym_q      <= '0;
            flush_pend <= 1'b0;
        end else if (!bus.enable) begin
            state      <= S_IDLE;
            shreg      <= '0;
            bcnt       <= '0;
            code       <= '0;
            len        <= '0;
            flush_pend <= 1'b0;
        end else begin
            case (state)
                S_IDLE: state <= S_FETCH;
                S_FETCH: begin
                    if (bus.flush) begin
                        shreg <= '0;
                        bcnt  <= '0;
                        code  <= '0;
                        len   <= '0;
                    end else if (bus.in_valid) begin
                        shreg <= bus.data_in;
                        bcnt  <= BCNT_W'(IN_W);
                        state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (bus.flush) begin
                        shreg <= '0;
                        bcnt  <= '0;
                        code  <= '0;
                        len   <= '0;
                        state <= S_FETCH;
                    end else begin
                        shreg <= shreg << 1;
                        bcnt  <= bcnt - BCNT_W'(1);
                        code  <= code_nxt;
                        len   <= len_nxt;
                        // code/len survive a FETCH so a code can straddle two words
                        if (lk.match) begin
                            sym_q <= SYM_W'(lk.sym);
                            state <= S_EMIT;
                        end else if (len_nxt == len_t'(MAX_LEN)) begin
                            state <= S_ERR;
                        end else if (bcnt == BCNT_W'(1)) begin
                            state <= S_FETCH;
                        end
                    end
                end
                S_EMIT: begin
                    if (bus.flush) flush_pend <= 1'b1;
                    if (bus.out_ready) begin
                        code       <= '0;
                        len        <= '0;
                        flush_pend <= 1'b0;
                        if (flush_pend || bus.flush) begin
                            shreg <= '0;
                            bcnt  <= '0;
                            state <= S_FETCH;
                        end else begin
                            state <= (bcnt == '0) ? S_FETCH : S_DECODE;
                        end
                    end
                end
                S_ERR:   state <= S_ERR;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_huffman_decoder.sv
// Directed bench for huffman_decoder: streams, backpressure, invalid code,
// flush, asynchronous reset and enable handling.
module tb_huffman_decoder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    huffman_decoder_if #(.IN_W(16), .SYM_W(8)) bus ();
    huffman_decoder #(.IN_W(16), .SYM_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));

    int total = 0;
    int bad   = 0;
    int stab_viol;
    logic [7:0] got[$];

    logic [7:0] exp_stream [12] = '{8'd5, 8'd68, 8'd50, 8'd100, 8'd150, 8'd200,
                                    8'd250, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5};
    // 16'h0007: twelve 0s -> 5 x6, then 01 -> 68; trailing 11 is flushed
    logic [7:0] exp_fl1 [7] = '{8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 8'd68};
    // 16'h4000: 01 -> 68, then fourteen 0s -> 5 x7
    logic [7:0] exp_fl2 [8] = '{8'd68, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5};

    function automatic logic [7:0] got_at(input int i);
        if (i < got.size()) return got[i];
        return 8'hxx;
    endfunction

    // Offers nw words and collects symbols until nsym arrive (bounded); starts at a negedge
    task automatic drive(input logic [15:0] w0, input logic [15:0] w1,
                         input int nw, input int nsym, input bit bp);
        int widx = 0;
        int cyc = 0;
        logic prev_hold = 1'b0;
        logic [7:0] prev_d = 8'h00;
        got.delete();
        stab_viol = 0;
        while (cyc < 400 && !(widx >= nw && got.size() >= nsym)) begin
            bus.in_valid  = (widx < nw);
            bus.data_in   = (widx == 0) ? w0 : w1;
            bus.out_ready = bp ? (cyc % 3 == 0) : 1'b1;
            #1;
            if (prev_hold && (!bus.out_valid || bus.data_out !== prev_d)) stab_viol++;
            prev_hold = bus.out_valid && !bus.out_ready;
            prev_d    = bus.data_out;
            if (bus.in_valid && bus.in_ready) widx++;
            if (bus.out_valid && bus.out_ready) got.push_back(bus.data_out);
            cyc++;
            @(negedge clk);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
    endtask

    task automatic pulse_flush();
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
    endtask

    task automatic test_reset();
        bus.enable = 1'b0; bus.in_valid = 1'b0; bus.data_in = '0;
        bus.flush = 1'b0; bus.out_ready = 1'b1;
        #2 rst = 1'b0;
        #1;
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b want=0", bus.in_ready); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
        total++; if (bus.data_out !== 8'd0) begin bad++; $display("FAIL reset_data_out got=%0d want=0", bus.data_out); end
        total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", bus.err); end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        bus.enable = 1'b1;
        @(negedge clk);
        #1;
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_fetch_ready got=%b want=1", bus.in_ready); end
        @(negedge clk);
    endtask

    task automatic test_basic();
        drive(16'h1977, 16'h7800, 2, 12, 1'b0);
        pulse_flush();
        total++; if (got.size() !== 12) begin bad++; $display("FAIL basic_count got=%0d want=12", got.size()); end
        for (int i = 0; i < 12; i++) begin
            total++;
            if (got_at(i) !== exp_stream[i]) begin bad++; $display("FAIL basic_sym%0d got=%0d want=%0d", i, got_at(i), exp_stream[i]); end
        end
        #1;
        total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL basic_err got=%b want=0", bus.err); end
        total++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            bad++; $display("FAIL basic_after_flush in_ready=%b out_valid=%b want 1/0", bus.in_ready, bus.out_valid);
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        drive(16'h1977, 16'h7800, 2, 12, 1'b1);
        pulse_flush();
        total++; if (got.size() !== 12) begin bad++; $display("FAIL bp_count got=%0d want=12", got.size()); end
        for (int i = 0; i < 12; i++) begin
            total++;
            if (got_at(i) !== exp_stream[i]) begin bad++; $display("FAIL bp_sym%0d got=%0d want=%0d", i, got_at(i), exp_stream[i]); end
        end
        total++; if (stab_viol !== 0) begin bad++; $display("FAIL bp_stable violations=%0d want=0", stab_viol); end
    endtask

    task automatic test_invalid();
        int seen_valid = 0;
        bus.in_valid = 1'b1; bus.data_in = 16'hF800;
        #1;
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL inv_accept got=%b want=1", bus.in_ready); end
        @(negedge clk);
        bus.in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1; if (bus.out_valid) seen_valid++;
            @(negedge clk);
        end
        #1;
        total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL inv_err_early got=%b want=0", bus.err); end
        @(negedge clk);
        bus.in_valid = 1'b1;
        #1;
        total++; if (bus.err !== 1'b1) begin bad++; $display("FAIL inv_err_set got=%b want=1", bus.err); end
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL inv_in_ready got=%b want=0", bus.in_ready); end
        @(negedge clk);
        #1;
        total++; if (bus.err !== 1'b1 || bus.out_valid !== 1'b0) begin
            bad++; $display("FAIL inv_sticky err=%b out_valid=%b want 1/0", bus.err, bus.out_valid);
        end
        total++; if (seen_valid !== 0) begin bad++; $display("FAIL inv_no_symbol got=%0d want=0", seen_valid); end
        bus.in_valid = 1'b0;
        bus.enable = 1'b0;
        @(negedge clk);
        #1;
        total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL inv_err_clear got=%b want=0", bus.err); end
        bus.enable = 1'b1;
        @(negedge clk);
        #1;
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL inv_refetch got=%b want=1", bus.in_ready); end
        @(negedge clk);
    endtask

    task automatic test_flush_mid();
        drive(16'h0007, 16'h0000, 1, 7, 1'b0);
        total++; if (got.size() !== 7) begin bad++; $display("FAIL flmid_count1 got=%0d want=7", got.size()); end
        for (int i = 0; i < 7; i++) begin
            total++;
            if (got_at(i) !== exp_fl1[i]) begin bad++; $display("FAIL flmid_a%0d got=%0d want=%0d", i, got_at(i), exp_fl1[i]); end
        end
        pulse_flush();
        drive(16'h4000, 16'h0000, 1, 8, 1'b0);
        total++; if (got.size() !== 8) begin bad++; $display("FAIL flmid_count2 got=%0d want=8", got.size()); end
        for (int i = 0; i < 8; i++) begin
            total++;
            if (got_at(i) !== exp_fl2[i]) begin bad++; $display("FAIL flmid_b%0d got=%0d want=%0d", i, got_at(i), exp_fl2[i]); end
        end
    endtask

    task automatic test_async_reset();
        bit found = 1'b0;
        bus.in_valid = 1'b1; bus.data_in = 16'h1977;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        #1 rst = 1'b0;
        #1;
        total++; if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.data_out !== 8'd0 || bus.err !== 1'b0) begin
            bad++; $display("FAIL arst_decode rdy=%b vld=%b dout=%0d err=%b want all 0", bus.in_ready, bus.out_valid, bus.data_out, bus.err);
        end
        #2 rst = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.data_in = 16'h1977;
        for (int i = 0; i < 12 && !found; i++) begin
            #1;
            if (bus.in_valid && bus.in_ready) begin
                @(negedge clk);
                bus.in_valid = 1'b0;
            end else if (bus.out_valid) begin
                found = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        bus.in_valid = 1'b0;
        total++; if (!found || bus.data_out !== 8'd5) begin
            bad++; $display("FAIL arst_emit_pre found=%b dout=%0d want 1/5", found, bus.data_out);
        end
        rst = 1'b0;
        #1;
        total++; if (bus.out_valid !== 1'b0 || bus.data_out !== 8'd0) begin
            bad++; $display("FAIL arst_emit vld=%b dout=%0d want 0/0", bus.out_valid, bus.data_out);
        end
        #2 rst = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        drive(16'h1977, 16'h7800, 2, 12, 1'b0);
        pulse_flush();
        total++; if (got.size() !== 12) begin bad++; $display("FAIL arst_count got=%0d want=12", got.size()); end
        for (int i = 0; i < 12; i++) begin
            total++;
            if (got_at(i) !== exp_stream[i]) begin bad++; $display("FAIL arst_sym%0d got=%0d want=%0d", i, got_at(i), exp_stream[i]); end
        end
    endtask

    task automatic test_enable_fetch();
        int seen_valid = 0;
        bus.enable = 1'b0; bus.in_valid = 1'b1; bus.data_in = 16'h0000;
        #1;
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL en_fetch_ready got=%b want=0", bus.in_ready); end
        @(negedge clk);
        #1;
        total++; if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
            bad++; $display("FAIL en_idle rdy=%b vld=%b want 0/0", bus.in_ready, bus.out_valid);
        end
        @(negedge clk);
        bus.enable = 1'b1; bus.in_valid = 1'b0;
        @(negedge clk);
        bus.flush = 1'b1; bus.in_valid = 1'b1;
        #1;
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL flush_wins got=%b want=0", bus.in_ready); end
        @(negedge clk);
        bus.flush = 1'b0; bus.in_valid = 1'b0;
        #1;
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL en_back_fetch got=%b want=1", bus.in_ready); end
        @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            #1; if (bus.out_valid) seen_valid++;
            @(negedge clk);
        end
        total++; if (seen_valid !== 0) begin bad++; $display("FAIL en_no_word got=%0d want=0", seen_valid); end
        drive(16'h4000, 16'h0000, 1, 8, 1'b0);
        for (int i = 0; i < 8; i++) begin
            total++;
            if (got_at(i) !== exp_fl2[i]) begin bad++; $display("FAIL en_sym%0d got=%0d want=%0d", i, got_at(i), exp_fl2[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_invalid();
        test_flush_mid();
        test_async_reset();
        test_enable_fetch();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end
endmodule
